// File: rtl/core_pkg.sv
// Shared definitions for the RV32I multi-cycle core.
//   seq_state_e      : phase encoding driven on core_seq.state (IDLE..HALT)
//   OP_LOAD/STORE/SYSTEM : major opcodes the sequencer decodes
//   bad_fetch_target : true when an address cannot be fetched (misaligned
//                      or outside instruction memory)
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_HALT    = 3'd6
  } seq_state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic bad_fetch_target(input logic [31:0] addr,
                                            input logic [31:0] limit);
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/seq_perf_cnt.sv
// Performance counters for the core sequencer.
//   clk, rst_n   : core clock, async active-low reset
//   retire       : one-cycle pulse per completed instruction
//   cycle_cnt    : cycles since reset, wraps at 2^64
//   instret_cnt  : retired instructions, wraps at 2^64
module seq_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        retire,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) instret_cnt <= instret_cnt + 64'd1;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle control sequencer for the RV32I core. Owns the PC and the
// phase bus, latches the fetched instruction, applies branch/jump redirects
// and stops the core on SYSTEM opcodes or an unfetchable next PC.
//   clk, rst_n            : core clock, async active-low reset
//   state                 : current phase (core_pkg::seq_state_e encoding)
//   pc                    : address of the current instruction
//   instr_in              : imem word, captured at the end of FETCH
//   ir                    : latched instruction register
//   pc_redirect/pc_target : taken branch/jump, honoured only in EXECUTE
//   dmem_ready            : data access complete, sampled in MEM
//   retire                : high during the final cycle of an instruction
//   halted, trap          : sticky stop flags (trap = bad fetch target)
//   cycle_cnt/instret_cnt : performance counters
// Optional feature: define SEQ_PERF_COUNTERS_EN to build the counters;
// otherwise both counter ports read as zero.
module core_seq
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32'd1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [2:0]  state,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  output logic [31:0] ir,
  input  logic        pc_redirect,
  input  logic [31:0] pc_target,
  input  logic        dmem_ready,
  output logic        retire,
  output logic        halted,
  output logic        trap,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  seq_state_e  st;
  logic [31:0] pc_next;
  logic [6:0]  opcode;
  logic        is_mem_op;
  logic        next_bad;

  assign opcode    = ir[6:0];
  assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign next_bad  = bad_fetch_target(pc_next, IMEM_BYTES);
  assign state     = st;

  // Retire cannot be a registered flag: a STORE completes in the very MEM
  // cycle where dmem_ready rises, so the pulse follows that input directly.
  assign retire = (st == ST_WB) ||
                  ((st == ST_MEM) && dmem_ready && (opcode == OP_STORE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      pc      <= RESET_PC;
      pc_next <= RESET_PC;
      ir      <= '0;
      halted  <= 1'b0;
      trap    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE:  st <= ST_FETCH;
        ST_FETCH: begin
          ir <= instr_in;
          st <= ST_DECODE;
        end
        ST_DECODE: begin
          if (opcode == OP_SYSTEM) begin
            st     <= ST_HALT;
            halted <= 1'b1;
          end else begin
            st <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          pc_next <= pc_redirect ? pc_target : pc + 32'd4;
          st      <= is_mem_op ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (opcode == OP_LOAD) begin
              st <= ST_WB;
            end else begin
              // STORE retires here; pc shows the new target even on a trap.
              pc <= pc_next;
              if (next_bad) begin
                st     <= ST_HALT;
                halted <= 1'b1;
                trap   <= 1'b1;
              end else begin
                st <= ST_FETCH;
              end
            end
          end
        end
        ST_WB: begin
          pc <= pc_next;
          if (next_bad) begin
            st     <= ST_HALT;
            halted <= 1'b1;
            trap   <= 1'b1;
          end else begin
            st <= ST_FETCH;
          end
        end
        ST_HALT: st <= ST_HALT;
        default: begin
          // Corrupted phase register: stop and flag it as a trap.
          st     <= ST_HALT;
          halted <= 1'b1;
          trap   <= 1'b1;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  seq_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .retire      (retire),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`else
  assign cycle_cnt   = 64'd0;
  assign instret_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a table of directed instructions with
// hand-derived results, hand-written multi-cycle corner sequences, and a
// randomized instruction stream checked against an instruction-level model.
`timescale 1ns/1ps
module tb_core_seq;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned IMEM_BYTES = 1048576;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  state;
  logic [31:0] pc, instr_in, ir, pc_target;
  logic        pc_redirect, dmem_ready, retire, halted, trap;
  logic [63:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  core_seq #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .pc(pc), .instr_in(instr_in),
    .ir(ir), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .dmem_ready(dmem_ready), .retire(retire), .halted(halted), .trap(trap),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Instruction-level model state.
  logic [31:0] m_pc;
  logic [63:0] m_cycles, m_instret;
  int          retire_seen = 0;

  always @(posedge clk) if (rst_n && retire) retire_seen++;

  function automatic logic [63:0] exp_cnt(input logic [63:0] v);
`ifdef SEQ_PERF_COUNTERS_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    m_cycles++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; instr_in = '0; pc_redirect = 1'b0; pc_target = '0; dmem_ready = 1'b0;
    #1;
    check("rst_state", state, S_IDLE);
    check("rst_pc", pc, RESET_PC);
    check("rst_ir", ir, 32'd0);
    check("rst_retire", retire, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_trap", trap, 1'b0);
    check("rst_cycle_cnt", cycle_cnt, 64'd0);
    check("rst_instret_cnt", instret_cnt, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cycles = 0; m_instret = 0; m_pc = RESET_PC;
    #1 check("idle_after_reset", state, S_IDLE);
    step();
  endtask

  // Runs one instruction starting in its FETCH cycle. The expected phase list
  // comes straight from the instruction class and stall count; inputs that
  // the sequencer should ignore are randomized.
  task automatic run_instr(input logic [31:0] instr, input int n_stall, input bit redir,
                           input logic [31:0] tgt, output bit stopped);
    logic [6:0]  op;
    bit          is_sys, is_ld, is_st, bad;
    logic [2:0]  exp_q[$];
    logic [31:0] nxt;
    op     = instr[6:0];
    is_sys = (op == 7'b1110011);
    is_ld  = (op == 7'b0000011);
    is_st  = (op == 7'b0100011);
    exp_q  = {S_FETCH, S_DECODE};
    if (!is_sys) begin
      exp_q.push_back(S_EXEC);
      if (is_ld || is_st) repeat (n_stall + 1) exp_q.push_back(S_MEM);
      if (!is_st) exp_q.push_back(S_WB);
    end
    nxt = redir ? tgt : m_pc + 32'd4;
    bad = (nxt % 4 != 0) || (nxt >= IMEM_BYTES);
    for (int i = 0; i < exp_q.size(); i++) begin
      instr_in    = (i == 0) ? instr : $urandom;
      pc_redirect = (i == 2) ? redir : 1'($urandom);
      pc_target   = (i == 2) ? tgt : $urandom;
      if (exp_q[i] == S_MEM) dmem_ready = (i == 3 + n_stall);
      else                   dmem_ready = 1'($urandom);
      #1;
      check("phase", state, exp_q[i]);
      check("pc_stable", pc, m_pc);
      check("retire", retire, !is_sys && (i == exp_q.size() - 1));
      check("halted_run", halted, 1'b0);
      if (i >= 1) check("ir", ir, instr);
      step();
    end
    if (!is_sys) begin
      m_instret++;
      m_pc = nxt;
    end
    #1;
    stopped = is_sys || bad;
    check("post_state", state, stopped ? S_HALT : S_FETCH);
    check("post_pc", pc, m_pc);
    check("post_halted", halted, stopped);
    check("post_trap", trap, !is_sys && bad);
    check("post_retire", retire, 1'b0);
    check("cycle_cnt", cycle_cnt, exp_cnt(m_cycles));
    check("instret_cnt", instret_cnt, exp_cnt(m_instret));
  endtask

  task automatic check_halt_hold(input bit exp_trap);
    repeat (3) begin
      instr_in = $urandom; pc_redirect = 1'b1; pc_target = $urandom & 32'hFFC;
      dmem_ready = 1'($urandom);
      step();
      #1;
      check("halt_state", state, S_HALT);
      check("halt_pc", pc, m_pc);
      check("halt_halted", halted, 1'b1);
      check("halt_trap", trap, exp_trap);
      check("halt_retire", retire, 1'b0);
      check("halt_cycle_cnt", cycle_cnt, exp_cnt(m_cycles));
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          n_stall;
    bit          redir;
    logic [31:0] tgt;
    logic [2:0]  exp_state;
    logic [31:0] exp_pc;
    bit          exp_halted;
    bit          exp_trap;
    int          exp_retires;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit          stopped;
    int          r0;
    logic [6:0]  alu_ops[5];
    logic [31:0] w, tgt;
    bit          redir;
    int          kind, sel;

    instr_in = '0; pc_redirect = 1'b0; pc_target = '0; dmem_ready = 1'b0;
    m_pc = RESET_PC; m_cycles = 0; m_instret = 0;

    //           instr          n  rd tgt            state    pc           h  t  ret
    vecs[0] = '{32'h0010_0093, 0, 0, 32'h0,          S_FETCH, 32'h4,       0, 0, 1}; // addi
    vecs[1] = '{32'h0000_0063, 0, 1, 32'h40,         S_FETCH, 32'h40,      0, 0, 1}; // beq taken
    vecs[2] = '{32'h0000_2083, 3, 0, 32'h0,          S_FETCH, 32'h4,       0, 0, 1}; // lw, 3 stalls
    vecs[3] = '{32'h0010_2023, 0, 0, 32'h0,          S_FETCH, 32'h4,       0, 0, 1}; // sw, no stall
    vecs[4] = '{32'h0000_006f, 0, 1, 32'h42,         S_HALT,  32'h42,      1, 1, 1}; // jal misaligned
    vecs[5] = '{32'h0000_006f, 0, 1, 32'h0010_0000,  S_HALT,  32'h0010_0000, 1, 1, 1}; // jal out of range
    vecs[6] = '{32'h0000_0073, 0, 0, 32'h0,          S_HALT,  32'h0,       1, 0, 0}; // ecall
    vecs[7] = '{32'h0010_0073, 0, 0, 32'h0,          S_HALT,  32'h0,       1, 0, 0}; // ebreak
    vecs[8] = '{32'h0000_006f, 0, 1, 32'h000F_FFFC,  S_FETCH, 32'h000F_FFFC, 0, 0, 1}; // last word

    for (int v = 0; v < 9; v++) begin
      do_reset();
      r0 = retire_seen;
      run_instr(vecs[v].instr, vecs[v].n_stall, vecs[v].redir, vecs[v].tgt, stopped);
      check($sformatf("vec%0d_state", v), state, vecs[v].exp_state);
      check($sformatf("vec%0d_pc", v), pc, vecs[v].exp_pc);
      check($sformatf("vec%0d_halted", v), halted, vecs[v].exp_halted);
      check($sformatf("vec%0d_trap", v), trap, vecs[v].exp_trap);
      check($sformatf("vec%0d_retires", v), retire_seen - r0, vecs[v].exp_retires);
      if (stopped) check_halt_hold(vecs[v].exp_trap);
    end

    // Sequential pc+4 from the last valid word crosses the memory limit.
    do_reset();
    run_instr(32'h0000_006f, 0, 1'b1, 32'h000F_FFFC, stopped);
    run_instr(32'h0010_0093, 0, 1'b0, 32'h0, stopped);
    check("seq_overflow_pc", pc, 32'h0010_0000);
    check("seq_overflow_trap", trap, 1'b1);
    check_halt_hold(1'b1);

    // Asynchronous reset in the middle of a stalled LOAD: no partial retire.
    do_reset();
    r0 = retire_seen;
    instr_in = 32'h0000_2083; pc_redirect = 1'b0; dmem_ready = 1'b0;
    step();
    step();
    pc_redirect = 1'b1; pc_target = 32'h80;
    step();
    #1 check("mid_in_mem", state, S_MEM);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_state", state, S_IDLE);
    check("mid_rst_pc", pc, RESET_PC);
    check("mid_rst_ir", ir, 32'd0);
    check("mid_rst_retire", retire, 1'b0);
    check("mid_rst_cycle_cnt", cycle_cnt, 64'd0);
    check("mid_rst_no_retire", retire_seen - r0, 0);

    // Randomized instruction stream.
    alu_ops[0] = 7'b0010011; alu_ops[1] = 7'b0110011; alu_ops[2] = 7'b1100011;
    alu_ops[3] = 7'b1101111; alu_ops[4] = 7'b0110111;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      w    = $urandom;
      kind = $urandom_range(0, 29);
      if (kind == 0)      w[6:0] = 7'b1110011;
      else if (kind < 9)  w[6:0] = 7'b0000011;
      else if (kind < 17) w[6:0] = 7'b0100011;
      else                w[6:0] = alu_ops[$urandom_range(0, 4)];
      redir = ($urandom_range(0, 9) < 3);
      sel   = $urandom_range(0, 19);
      if (sel == 0)      tgt = ($urandom_range(0, 262143) << 2) | $urandom_range(1, 3);
      else if (sel == 1) tgt = 32'h0010_0000 + ($urandom_range(0, 1000) << 2);
      else if (sel == 2) tgt = 32'hFFFF_FFFC;
      else               tgt = $urandom_range(0, 262143) << 2;
      run_instr(w, $urandom_range(0, 3), redir, tgt, stopped);
      if (stopped) begin
        check_halt_hold(trap === 1'b1 ? 1'b1 : (w[6:0] != 7'b1110011));
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
